// File: rtl/gcd_param_unit.sv
// Iterative subtractive GCD unit with a valid/ready handshake on both sides.
// Optional CALC-cycle counter port enabled by defining GCD_CYCLE_COUNT_EN.
module gcd_param_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [WIDTH-1:0] cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_accept;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out       = r_out;

    // One GCD step per CALC cycle; the larger operand is always the minuend.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_out_nxt   = r_out;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_nxt     = in1;
                    w_b_nxt     = in2;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if ((r_a == '0) || (r_b == '0)) begin
                    w_out_nxt   = r_a | r_b;
                    w_state_nxt = S_DONE;
                end else if (r_a == r_b) begin
                    w_out_nxt   = r_a;
                    w_state_nxt = S_DONE;
                end else if (r_a > r_b) begin
                    w_a_nxt = r_a - r_b;
                end else begin
                    w_b_nxt = r_b - r_a;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_out   <= w_out_nxt;
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == '1) ? v : v + WIDTH'(1);
    endfunction

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_accept) begin
            w_cnt_nxt = '0;
        end else if (r_state == S_CALC) begin
            w_cnt_nxt = sat_inc(r_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign cycles = r_cnt;
`endif

endmodule

// File: tb/tb_gcd_param_unit.sv
// Directed self-checking bench for gcd_param_unit at WIDTH=8 and WIDTH=16.
module tb_gcd_param_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out;
    logic        busy;
`ifdef GCD_CYCLE_COUNT_EN
    logic [7:0]  cycles;
`endif

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] in1_16;
    logic [15:0] in2_16;
    logic        out_valid16;
    logic        out_ready16;
    logic [15:0] out16;
    logic        busy16;
`ifdef GCD_CYCLE_COUNT_EN
    logic [15:0] cycles16;
`endif

    gcd_param_unit #(.WIDTH(8)) u8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .busy     (busy)
`ifdef GCD_CYCLE_COUNT_EN
        ,
        .cycles   (cycles)
`endif
    );

    gcd_param_unit #(.WIDTH(16)) u16 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid16),
        .in_ready (in_ready16),
        .in1      (in1_16),
        .in2      (in2_16),
        .out_valid(out_valid16),
        .out_ready(out_ready16),
        .out      (out16),
        .busy     (busy16)
`ifdef GCD_CYCLE_COUNT_EN
        ,
        .cycles   (cycles16)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a pair for one edge, then scramble the operand inputs.
    task automatic accept8(input string tag, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1 = 8'hAA;
        in2 = 8'h55;
    endtask

    task automatic wait_done8(input int budget, output int k, output bit busy_ok);
        k = 0;
        busy_ok = 1'b1;
        while (k < budget) begin
            @(posedge clk);
            #1;
            k++;
            if (out_valid) break;
            if (!busy) busy_ok = 1'b0;
        end
        if (!out_valid) k = -1;
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_out, input int exp_k);
        int k;
        bit bok;
        accept8(tag, a, b);
        wait_done8(300, k, bok);
        check_eq({tag, "_latency"}, 32'(k), 32'(exp_k));
        check_eq({tag, "_out"}, 32'(out), 32'(exp_out));
        check_eq({tag, "_busy"}, 32'(bok), 32'd1);
`ifdef GCD_CYCLE_COUNT_EN
        check_eq({tag, "_cycles"}, 32'(cycles), 32'(exp_k));
`endif
        @(posedge clk);
        #1;
        check_eq({tag, "_consumed"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_out, input int exp_k);
        int k;
        @(negedge clk);
        in1_16 = a;
        in2_16 = b;
        in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        k = 0;
        while (k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (out_valid16) break;
        end
        if (!out_valid16) k = -1;
        check_eq({tag, "_latency"}, 32'(k), 32'(exp_k));
        check_eq({tag, "_out"}, 32'(out16), 32'(exp_out));
        @(posedge clk);
        #1;
        check_eq({tag, "_consumed"}, 32'(out_valid16), 32'd0);
    endtask

    initial begin
        int k;
        bit bok;
        rst = 1'b1;
        in_valid = 1'b0;
        in1 = '0;
        in2 = '0;
        out_ready = 1'b1;
        in_valid16 = 1'b0;
        in1_16 = '0;
        in2_16 = '0;
        out_ready16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out", 32'(out), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out16", 32'(out16), 32'd0);
        rst = 1'b0;

        run8("g12_18", 8'd12, 8'd18, 8'd6, 3);
        run8("g0_45", 8'd0, 8'd45, 8'd45, 1);
        run8("g0_0", 8'd0, 8'd0, 8'd0, 1);
        run8("g45_0", 8'd45, 8'd0, 8'd45, 1);
        run8("g255_1", 8'd255, 8'd1, 8'd1, 255);

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        accept8("g48_36", 8'd48, 8'd36);
        wait_done8(50, k, bok);
        check_eq("g48_36_latency", 32'(k), 32'd4);
        check_eq("g48_36_out", 32'(out), 32'd12);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in1 = 8'd99;
            in2 = 8'd3;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_eq("stall_out", 32'(out), 32'd12);
            check_eq("stall_out_valid", 32'(out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
            check_eq("stall_cycles", 32'(cycles), 32'd4);
`endif
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in1 = 8'd5;
        in2 = 8'd10;
        @(posedge clk);
        #1;
        check_eq("release_out_valid", 32'(out_valid), 32'd0);
        check_eq("release_out_kept", 32'(out), 32'd12);
        check_eq("release_in_ready", 32'(in_ready), 32'd1);
        check_eq("release_no_accept", 32'(busy), 32'd0);
        in_valid = 1'b0;

        // Abort a long computation with reset.
        accept8("g200_3", 8'd200, 8'd3);
        repeat (9) @(posedge clk);
        #1;
        check_eq("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_out", 32'(out), 32'd0);
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
        check_eq("abort_cycles", 32'(cycles), 32'd0);
`endif
        run8("g7_21", 8'd7, 8'd21, 8'd7, 3);

        run16("w16_max", 16'd65535, 16'd65535, 16'd65535, 1);
        run16("w16_40k_30k", 16'd40000, 16'd30000, 16'd10000, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_param_unit.md
GCD_PARAM_UNIT -- requirements
Module: gcd_param_unit

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: in_valid  input  1  operand pair in1/in2 is valid.
REQ-005 Port: in_ready  output  1  block can accept an operand pair.
REQ-006 Port: in1  input  WIDTH  operand A, unsigned.
REQ-007 Port: in2  input  WIDTH  operand B, unsigned.
REQ-008 Port: out_valid  output  1  out holds a completed result.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: out  output  WIDTH  registered GCD result.
REQ-011 Port: busy  output  1  high in CALC and DONE states.
REQ-012 Port (GCD_CYCLE_COUNT_EN only): cycles  output  WIDTH  number of CALC cycles spent on the current result.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE; encoding is free.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready at an edge, register a<=in1, b<=in2, go to CALC.
REQ-015 CALC, one step per cycle, priority order: a==0 or b==0 -> out<=a|b, go DONE; a==b -> out<=a, go DONE; a>b -> a<=a-b; else b<=b-a.
REQ-016 Subtraction SHALL be WIDTH-bit unsigned; operands never underflow because the larger is always the minuend.
REQ-017 Latency: out_valid SHALL rise k cycles after the acceptance edge, k = number of CALC steps including the terminating step; (12,18) gives k=3.
REQ-018 Worst case k = 2^WIDTH-1 (operands (2^WIDTH-1,1)); no timeout.
REQ-019 DONE: out_valid=1, out and cycles held stable while out_ready=0.
REQ-020 DONE with out_ready=1 at an edge: go IDLE; out_valid falls next cycle; out retains last value.
REQ-021 in_ready SHALL be 0 in CALC and DONE; no new operand is accepted in the same cycle a result is consumed.
REQ-022 in1/in2 changes outside the acceptance edge SHALL have no effect.
REQ-023 in_valid SHALL not be required to stay high after acceptance; out_ready may be held high permanently.

Reset
REQ-024 rst=1 at an edge forces IDLE, a=0, b=0, out=0, out_valid=0, cycles=0, regardless of state.
REQ-025 Reset mid-CALC or mid-DONE SHALL abort the operation with no result presented; in_ready=1 the cycle after rst deasserts.
REQ-026 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-027 Macro GCD_CYCLE_COUNT_EN defined: cycles port present; cleared on acceptance, +1 per CALC cycle, saturating at 2^WIDTH-1, held in DONE and IDLE.
REQ-028 Macro GCD_CYCLE_COUNT_EN undefined: no cycles port, no counter logic; all other behaviour identical.

Verification
REQ-029 WIDTH=8, in1=12, in2=18, out_ready=1 -> out=6, out_valid 3 cycles after acceptance, cycles=3.
REQ-030 WIDTH=8, (0,45) -> out=45 after 1 cycle; (0,0) -> out=0 after 1 cycle; (45,0) -> out=45.
REQ-031 WIDTH=8, (255,1) -> out=1 after 255 cycles, cycles=255, busy high throughout.
REQ-032 (48,36), out_ready=0 for 5 cycles after out_valid -> out=12 stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 (200,3) accepted, rst pulsed on CALC cycle 10 -> out=0, out_valid=0 next cycle; new pair (7,21) -> out=7 normally.
REQ-034 WIDTH=16, (65535,65535) -> out=65535 after 1 cycle; (40000,30000) -> out=10000.
